// File: rtl/bus2_link_tx.sv
// bus2_link_tx: serialises a parallel word into LSB-first 2-bit beats plus an even-parity beat
module bus2_link_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int IDLE_GAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [1:0]            bus_out,
  output logic                  bus_frame,
  output logic                  bus_last,
  input  logic                  bus_hold
);
  localparam int BEATS = DATA_WIDTH / 2;
  localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, GAP} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            gap_q, gap_d;
  logic [1:0]            out_q, out_d;
  logic                  par_q, par_d, ready_q, ready_d, frame_q, frame_d, last_q, last_d;
  // next-state and next-output logic; every output is registered, so it is computed one cycle ahead
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ready_d = ready_q;
    out_d   = out_q;
    frame_d = frame_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (ready_q && in_valid) begin
          state_d = DATA;
          shreg_d = in_data;
          par_d   = ^in_data;
          cnt_d   = '0;
          ready_d = 1'b0;
          out_d   = in_data[1:0];
          frame_d = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      DATA: begin
        if (!bus_hold) begin
          if (cnt_q == CW'(BEATS - 1)) begin
            state_d = PARITY;
            out_d   = {1'b0, par_q};
            last_d  = 1'b1;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = shreg_q >> 2;
            out_d   = shreg_d[1:0];
          end
        end
      end
      PARITY: begin
        if (!bus_hold) begin
          state_d = IDLE_GAP == 0 ? IDLE : GAP;
          ready_d = IDLE_GAP == 0;
          gap_d   = '0;
          out_d   = 2'b00;
          frame_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      default: begin
        if (gap_q == 4'(IDLE_GAP - 1)) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
    endcase
  end
  // state and output registers; reset abandons any frame in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      gap_q   <= '0;
      ready_q <= 1'b0;
      out_q   <= 2'b00;
      frame_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      ready_q <= ready_d;
      out_q   <= out_d;
      frame_q <= frame_d;
      last_q  <= last_d;
    end
  end
  assign in_ready  = ready_q;
  assign bus_out   = out_q;
  assign bus_frame = frame_q;
  assign bus_last  = last_q;
endmodule

// File: tb/tb_bus2_link_tx.sv
// tb_bus2_link_tx: randomized and directed checks of bus2_link_tx against a queue-based frame model
module tb_bus2_link_tx;
  localparam int DW = 8, IG = 1, BEATS = DW / 2;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0, bus_hold = 1'b0;
  logic          in_ready, bus_frame, bus_last;
  logic [1:0]    bus_out;
  logic [1:0]    d2_data = 2'b00, d2_out;
  logic          d2_valid = 1'b0, d2_hold = 1'b0, d2_ready, d2_frame, d2_last;
  int            vectors = 0, miscompares = 0;
  logic [1:0]    exp_q[$];
  int            gap_left = 0, ncyc = 0, last_start = 0, dut_gap = 0, frame_cnt = 0;
  bit            m_ready = 0, prev_frame = 0;

  always #5 clk = ~clk;

  bus2_link_tx #(.DATA_WIDTH(DW), .IDLE_GAP(IG)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bus_out(bus_out), .bus_frame(bus_frame), .bus_last(bus_last), .bus_hold(bus_hold));

  bus2_link_tx #(.DATA_WIDTH(2), .IDLE_GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2_data), .in_valid(d2_valid), .in_ready(d2_ready),
    .bus_out(d2_out), .bus_frame(d2_frame), .bus_last(d2_last), .bus_hold(d2_hold));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // model: a queue of beats still to be shown (data beats then parity), then a gap countdown
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      gap_left = 0;
      m_ready  = 0;
    end else if (exp_q.size() > 0) begin
      if (!bus_hold) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          gap_left = IG;
          m_ready  = (IG == 0);
        end
      end
    end else if (gap_left > 0) begin
      gap_left--;
      m_ready = (gap_left == 0);
    end else if (!m_ready) begin
      m_ready = 1;
    end else if (in_valid) begin
      for (int i = 0; i < BEATS; i++) exp_q.push_back(in_data[2*i +: 2]);
      exp_q.push_back({1'b0, ^in_data});
      m_ready = 0;
    end
  end

  always @(negedge clk) begin
    ncyc++;
    check("in_ready", in_ready, m_ready);
    check("bus_frame", bus_frame, exp_q.size() > 0);
    check("bus_last", bus_last, exp_q.size() == 1);
    check("bus_out", bus_out, exp_q.size() > 0 ? exp_q[0] : 2'b00);
    if (bus_frame) frame_cnt++;
    if (bus_frame && !prev_frame) begin
      dut_gap    = ncyc - last_start;
      last_start = ncyc;
    end
    prev_frame = bus_frame;
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
  endtask

  task automatic send(input logic [DW-1:0] w);
    wait_ready();
    in_data  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_out", bus_out, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_rst", in_ready, 1);
    send(8'hB4);
    repeat (5) @(posedge clk);
    #1 check("ready_e5", in_ready, 0);
    @(posedge clk); #1 check("ready_e6", in_ready, 1);
    wait_ready();
    in_data  = 8'h01;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'hFF;
    repeat (7) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk); #1;
    check("stream_period", dut_gap, 7);
    wait_ready();
    frame_cnt = 0;
    send(8'hB4);
    repeat (2) @(posedge clk);
    #1 bus_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus_hold = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus_hold = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("hold_frame_len", frame_cnt, 10);
    send(8'hB4);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out", bus_out, 0);
    check("midrst_frame", bus_frame, 0);
    check("midrst_ready", in_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'h3C);
    repeat (8) @(posedge clk);
    repeat (300) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 2) != 0;
      in_data  = DW'($urandom);
      bus_hold = $urandom_range(0, 3) == 0;
    end
    in_valid = 1'b0;
    bus_hold = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("d2_ready_idle", d2_ready, 1);
    d2_data  = 2'b10;
    d2_valid = 1'b1;
    @(posedge clk); #1;
    check("d2_beat", d2_out, 2'b10);
    check("d2_beat_frame", d2_frame, 1);
    check("d2_beat_last", d2_last, 0);
    check("d2_beat_ready", d2_ready, 0);
    @(posedge clk); #1;
    check("d2_par", d2_out, 2'b01);
    check("d2_par_last", d2_last, 1);
    @(posedge clk); #1;
    check("d2_ready_back", d2_ready, 1);
    check("d2_idle_frame", d2_frame, 0);
    @(posedge clk); #1;
    check("d2_period", d2_frame, 1);
    check("d2_period_out", d2_out, 2'b10);
    d2_valid = 1'b0;
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
